// File: rtl/canvas_write_arbiter.sv
// Single write-port owner for the 320x240 canvas BRAM: draw > host > clear priority,
// with a background full-canvas clear sequencer and a one-cycle registered write path.
module canvas_write_arbiter #(
  parameter int unsigned              ADDR_W     = 17,
  parameter int unsigned              DATA_W     = 8,
  parameter int unsigned              NUM_PIXELS = 76800,
  parameter logic [DATA_W-1:0]        CLEAR_VAL  = 8'h00
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              draw_valid_in,
  input  logic [ADDR_W-1:0] draw_addr_in,
  input  logic [DATA_W-1:0] draw_data_in,
  input  logic              host_valid_in,
  output logic              host_ready_out,
  input  logic [ADDR_W-1:0] host_addr_in,
  input  logic [DATA_W-1:0] host_data_in,
  input  logic              clear_req_in,
  output logic              clear_busy_out,
  output logic              clear_done_out,
  output logic              bram_we_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [DATA_W-1:0] bram_data_out,
  output logic [1:0]        grant_out
);

  typedef enum logic {
    IDLE,
    CLEARING
  } state_t;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'b00,
    GRANT_DRAW  = 2'b01,
    GRANT_HOST  = 2'b10,
    GRANT_CLEAR = 2'b11
  } grant_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clear_cnt;
  logic              host_xfer;
  logic              draw_in_range;
  logic              host_in_range;
  logic              clear_win;

  // The draw pipeline cannot stall, so the host only moves when draw is silent.
  assign host_ready_out = !draw_valid_in;
  assign host_xfer      = host_valid_in && host_ready_out;
  assign draw_in_range  = 32'(draw_addr_in) < NUM_PIXELS;
  assign host_in_range  = 32'(host_addr_in) < NUM_PIXELS;

  // An out-of-range draw or host transfer still occupies the slot, so clear waits.
  assign clear_win = (state == CLEARING) && !draw_valid_in && !host_xfer;

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every
  // register here, including the clear counter, so an aborted clear never resumes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      clear_cnt      <= '0;
      clear_busy_out <= 1'b0;
      clear_done_out <= 1'b0;
      bram_we_out    <= 1'b0;
      bram_addr_out  <= '0;
      bram_data_out  <= '0;
      grant_out      <= GRANT_NONE;
    end else begin
      // NOTE: per-cycle strobes default low; address/data deliberately hold their last values.
      bram_we_out    <= 1'b0;
      grant_out      <= GRANT_NONE;
      clear_done_out <= 1'b0;

      if (draw_valid_in) begin
        if (draw_in_range) begin
          bram_we_out   <= 1'b1;
          bram_addr_out <= draw_addr_in;
          bram_data_out <= draw_data_in;
          grant_out     <= GRANT_DRAW;
        end
      end else if (host_xfer) begin
        if (host_in_range) begin
          bram_we_out   <= 1'b1;
          bram_addr_out <= host_addr_in;
          bram_data_out <= host_data_in;
          grant_out     <= GRANT_HOST;
        end
      end else if (clear_win) begin
        bram_we_out   <= 1'b1;
        bram_addr_out <= clear_cnt;
        bram_data_out <= CLEAR_VAL;
        grant_out     <= GRANT_CLEAR;
      end

      case (state)
        IDLE: begin
          if (clear_req_in) begin
            state          <= CLEARING;
            clear_cnt      <= '0;
            clear_busy_out <= 1'b1;
          end
        end
        CLEARING: begin
          if (clear_win) begin
            if (clear_cnt == LAST_ADDR) begin
              clear_cnt      <= '0;
              state          <= IDLE;
              clear_busy_out <= 1'b0;
              clear_done_out <= 1'b1;
            end else begin
              clear_cnt <= clear_cnt + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Scoreboard bench for canvas_write_arbiter: stimulus pushes expected BRAM writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_canvas_write_arbiter;

  localparam int unsigned NUM_PIXELS = 76800;

  typedef struct {
    logic [1:0]  grant;
    logic [16:0] addr;
    logic [7:0]  data;
    logic        done;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        draw_valid_in = 1'b0;
  logic [16:0] draw_addr_in = '0;
  logic [7:0]  draw_data_in = '0;
  logic        host_valid_in = 1'b0;
  logic        host_ready_out;
  logic [16:0] host_addr_in = '0;
  logic [7:0]  host_data_in = '0;
  logic        clear_req_in = 1'b0;
  logic        clear_busy_out;
  logic        clear_done_out;
  logic        bram_we_out;
  logic [16:0] bram_addr_out;
  logic [7:0]  bram_data_out;
  logic [1:0]  grant_out;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  bit   m_clearing = 1'b0;
  int   m_cnt = 0;

  canvas_write_arbiter dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .draw_valid_in  (draw_valid_in),
    .draw_addr_in   (draw_addr_in),
    .draw_data_in   (draw_data_in),
    .host_valid_in  (host_valid_in),
    .host_ready_out (host_ready_out),
    .host_addr_in   (host_addr_in),
    .host_data_in   (host_data_in),
    .clear_req_in   (clear_req_in),
    .clear_busy_out (clear_busy_out),
    .clear_done_out (clear_done_out),
    .bram_we_out    (bram_we_out),
    .bram_addr_out  (bram_addr_out),
    .bram_data_out  (bram_data_out),
    .grant_out      (grant_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in) begin
        if (bram_we_out) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0h data %0h grant %0h expected no write",
                     bram_addr_out, bram_data_out, grant_out);
          end else begin
            e = exp_q.pop_front();
            check("wr_grant", 32'(grant_out), 32'(e.grant));
            check("wr_addr", 32'(bram_addr_out), 32'(e.addr));
            check("wr_data", 32'(bram_data_out), 32'(e.data));
            check("wr_done", 32'(clear_done_out), 32'(e.done));
          end
        end else begin
          check("idle_grant", 32'(grant_out), 32'(0));
          check("idle_done", 32'(clear_done_out), 32'(0));
        end
        if (clear_done_out) done_cnt++;
      end
    end
  end

  // One cycle of stimulus; the expected winner is queued before the clock edge.
  task automatic drive(input logic dv, input logic [16:0] da, input logic [7:0] dd,
                       input logic hv, input logic [16:0] ha, input logic [7:0] hd,
                       input logic cr);
    exp_t e;
    bit   was_clearing;
    was_clearing  = m_clearing;
    draw_valid_in = dv;
    draw_addr_in  = da;
    draw_data_in  = dd;
    host_valid_in = hv;
    host_addr_in  = ha;
    host_data_in  = hd;
    clear_req_in  = cr;
    #1;
    check("host_ready", 32'(host_ready_out), 32'(!dv));
    if (dv) begin
      if (32'(da) < NUM_PIXELS) begin
        e = '{2'b01, da, dd, 1'b0};
        exp_q.push_back(e);
      end
    end else if (hv) begin
      if (32'(ha) < NUM_PIXELS) begin
        e = '{2'b10, ha, hd, 1'b0};
        exp_q.push_back(e);
      end
    end else if (was_clearing) begin
      e = '{2'b11, 17'(m_cnt), 8'h00, (m_cnt == NUM_PIXELS - 1)};
      exp_q.push_back(e);
      if (m_cnt == NUM_PIXELS - 1) begin
        m_clearing = 1'b0;
        m_cnt      = 0;
      end else begin
        m_cnt++;
      end
    end
    if (!was_clearing && cr) begin
      m_clearing = 1'b1;
      m_cnt      = 0;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_in);
    #1;
    draw_valid_in = 1'b0;
    host_valid_in = 1'b0;
    clear_req_in  = 1'b0;
    rst_n_in      = 1'b0;
    #1;
    check({tag, "_we"},    32'(bram_we_out),    32'(0));
    check({tag, "_addr"},  32'(bram_addr_out),  32'(0));
    check({tag, "_data"},  32'(bram_data_out),  32'(0));
    check({tag, "_grant"}, 32'(grant_out),      32'(0));
    check({tag, "_busy"},  32'(clear_busy_out), 32'(0));
    check({tag, "_done"},  32'(clear_done_out), 32'(0));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    m_clearing = 1'b0;
    m_cnt      = 0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    do_reset("por");

    // Draw beats host in the same cycle; host follows on the next free cycle.
    drive(1'b1, 17'd5, 8'hC1, 1'b1, 17'd7, 8'hC2, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 17'd7, 8'hC2, 1'b0);
    // Out-of-range host write is consumed but produces no write; addr/data hold.
    drive(1'b0, '0, '0, 1'b1, 17'h12C01, 8'hAA, 1'b0);
    check("oor_host_we", 32'(bram_we_out), 32'(0));
    check("oor_host_grant", 32'(grant_out), 32'(0));
    check("oor_hold_addr", 32'(bram_addr_out), 32'(7));
    check("oor_hold_data", 32'(bram_data_out), 32'(8'hC2));
    // First illegal draw address stalls the host at the last legal address.
    drive(1'b1, 17'd76800, 8'hC5, 1'b1, 17'd76799, 8'hC6, 1'b0);
    check("oor_draw_we", 32'(bram_we_out), 32'(0));
    drive(1'b0, '0, '0, 1'b1, 17'd76799, 8'hC6, 1'b0);
    idle(2);

    // Abort a clear at counter 1000 with reset: no done pulse, restart from 0.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    check("busy_after_req", 32'(clear_busy_out), 32'(1));
    idle(1000);
    check("busy_mid_clear", 32'(clear_busy_out), 32'(1));
    do_reset("abort");
    check("abort_no_done", 32'(done_cnt), 32'(0));

    // Second clear request at counter 500 is ignored.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(500);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(100);
    check("busy_after_ignored_req", 32'(clear_busy_out), 32'(1));
    do_reset("restart");

    // Draw + host + clear together, then contention every 4th cycle.
    drive(1'b1, 17'd10, 8'hC3, 1'b1, 17'd11, 8'hC4, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 17'd11, 8'hC4, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (i % 4 == 0)
        drive(1'b1, 17'(2000 + i), 8'hC0 | 8'(i[5:0]), 1'b0, '0, '0, 1'b0);
      else if (i % 16 == 6)
        drive(1'b0, '0, '0, 1'b1, 17'(3000 + i), 8'hC0 | 8'(i[5:0]), 1'b0);
      else
        idle(1);
    end
    do_reset("contend");

    // Uncontended full clear.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(NUM_PIXELS);
    check("final_done", 32'(clear_done_out), 32'(1));
    check("final_busy", 32'(clear_busy_out), 32'(0));
    check("final_addr", 32'(bram_addr_out), 32'(76799));
    idle(1);
    check("done_single_cycle", 32'(clear_done_out), 32'(0));
    check("done_count", 32'(done_cnt), 32'(1));

    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
